j_latch_wr_arb: RTL and testbench

Write scheduler for a bank of enable-latched, settable registers (mux-feedback latch plus flip-flop with active-low preset). Two requesters, host bus (port 0) and DSP (port 1), share one latch write path. The block arbitrates round-robin, issues one-hot latch enables with the write data, and sequences a timed preset of the whole bank after reset. It sits between the Jerry bus/DSP write decode and the latch bank.

---
 rtl/j_latch_wr_arb.sv | 117 +++++++++++
 tb/tb_j_latch_wr_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/j_latch_wr_arb.sv
// Write scheduler for an enable-latched register bank: round-robin arbitration of
// two write ports, a registered one-hot write stage and a timed bank preset after reset.
module j_latch_wr_arb #(
  parameter int NREG       = 8,
  parameter int AW         = 3,
  parameter int DW         = 16,
  parameter int PRESET_CYC = 4
) (
  input  logic            sys_clk,
  input  logic            resetl,
  input  logic            req0,
  input  logic [AW-1:0]   addr0,
  input  logic [DW-1:0]   data0,
  output logic            gnt0,
  input  logic            req1,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   data1,
  output logic            gnt1,
  output logic [DW-1:0]   lat_d,
  output logic [NREG-1:0] lat_en,
  output logic            lat_setl,
  output logic            busy,
  output logic            err
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [3:0] PRESET_W = 4'(PRESET_CYC);
  localparam logic [AW:0] NREG_W  = (AW+1)'(NREG);

  state_t          state;
  logic [3:0]      cnt;
  logic            ptr;
  logic            wr_pend;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;

  logic            sel0;
  logic            sel1;
  logic [NREG-1:0] en_next;
  logic            err_next;

  // ptr names the port that wins when both request at once
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (state == RUN) begin
      sel0 = req0 && (!req1 || !ptr);
      sel1 = req1 && (!req0 || ptr);
    end
  end

  // Decode the captured address; out-of-range indices fall through to err
  always_comb begin
    en_next = '0;
    for (int i = 0; i < NREG; i++) begin
      en_next[i] = wr_pend && (wr_addr == AW'(i));
    end
    err_next = wr_pend && !({1'b0, wr_addr} < NREG_W);
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      state    <= INIT;
      cnt      <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      lat_en   <= '0;
      lat_d    <= '0;
      err      <= 1'b0;
      lat_setl <= 1'b0;
      busy     <= 1'b1;
      ptr      <= 1'b0;
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      lat_en  <= en_next;
      err     <= err_next;
      if (wr_pend) begin
        lat_d <= wr_data;
      end
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      wr_pend <= 1'b0;
      case (state)
        INIT: begin
          if (cnt == PRESET_W) begin
            state    <= RUN;
            lat_setl <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RUN: begin
          // Winner's address and data are captured with the grant
          if (sel0) begin
            gnt0    <= 1'b1;
            ptr     <= 1'b1;
            wr_pend <= 1'b1;
            wr_addr <= addr0;
            wr_data <= data0;
          end else if (sel1) begin
            gnt1    <= 1'b1;
            ptr     <= 1'b0;
            wr_pend <= 1'b1;
            wr_addr <= addr1;
            wr_data <= data1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_j_latch_wr_arb.sv
// Bench for j_latch_wr_arb: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model; a second instance uses NREG=6 for range errors.
module tb_j_latch_wr_arb;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int PC = 4;

  logic          sys_clk = 1'b0;
  logic          resetl;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;

  logic          gnt0, gnt1, lat_setl, busy, err;
  logic [DW-1:0] lat_d;
  logic [7:0]    lat_en;
  logic          gnt0_6, gnt1_6, lat_setl_6, busy_6, err_6;
  logic [DW-1:0] lat_d_6;
  logic [5:0]    lat_en_6;

  int total = 0;
  int bad   = 0;

  // model state: edges since release, last winner, grant waiting for its write stage
  int            m_rel;
  int            m_last;
  bit            m_pv;
  int            m_pa;
  logic [DW-1:0] m_pd;
  logic          e_gnt0, e_gnt1, e_setl, e_busy, e_err6;
  logic [DW-1:0] e_d;
  logic [7:0]    e_en8;
  logic [5:0]    e_en6;
  bit            auto_mode = 0;

  j_latch_wr_arb #(.NREG(8), .AW(AW), .DW(DW), .PRESET_CYC(PC)) u_dut (
    .sys_clk(sys_clk), .resetl(resetl),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
    .lat_d(lat_d), .lat_en(lat_en), .lat_setl(lat_setl), .busy(busy), .err(err)
  );

  j_latch_wr_arb #(.NREG(6), .AW(AW), .DW(DW), .PRESET_CYC(PC)) u_dut6 (
    .sys_clk(sys_clk), .resetl(resetl),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0_6),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1_6),
    .lat_d(lat_d_6), .lat_en(lat_en_6), .lat_setl(lat_setl_6), .busy(busy_6), .err(err_6)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour, evaluated with the inputs seen at each rising edge
  task automatic modelEdge();
    int  w;
    bit  running;
    if (!resetl) begin
      m_rel = 0; m_last = 1; m_pv = 0;
      e_gnt0 = 0; e_gnt1 = 0; e_d = '0; e_en8 = '0; e_en6 = '0; e_err6 = 0;
      e_setl = 0; e_busy = 1;
    end else begin
      running = (m_rel > PC);
      e_en8 = '0; e_en6 = '0; e_err6 = 0;
      if (m_pv) begin
        e_d = m_pd;
        if (m_pa < 8) e_en8[m_pa] = 1'b1;
        if (m_pa < 6) e_en6[m_pa] = 1'b1;
        else          e_err6 = 1'b1;
      end
      m_pv = 0; e_gnt0 = 0; e_gnt1 = 0;
      if (running) begin
        if (req0 && req1) w = 1 - m_last;
        else if (req0)    w = 0;
        else if (req1)    w = 1;
        else              w = -1;
        if (w >= 0) begin
          m_last = w; m_pv = 1;
          m_pa = (w == 0) ? int'(addr0) : int'(addr1);
          m_pd = (w == 0) ? data0 : data1;
          if (w == 0) e_gnt0 = 1; else e_gnt1 = 1;
        end
      end
      if (m_rel < 1000) m_rel++;
      e_setl = (m_rel > PC);
      e_busy = !e_setl;
    end
  endtask

  task automatic compareAll();
    checkOutput("gnt0", 32'(gnt0), 32'(e_gnt0));
    checkOutput("gnt1", 32'(gnt1), 32'(e_gnt1));
    checkOutput("lat_d", 32'(lat_d), 32'(e_d));
    checkOutput("lat_en", 32'(lat_en), 32'(e_en8));
    checkOutput("lat_setl", 32'(lat_setl), 32'(e_setl));
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("err", 32'(err), 32'(0));
    checkOutput("gnt_n6", 32'({gnt1_6, gnt0_6}), 32'({e_gnt1, e_gnt0}));
    checkOutput("lat_d_n6", 32'(lat_d_6), 32'(e_d));
    checkOutput("lat_en_n6", 32'(lat_en_6), 32'(e_en6));
    checkOutput("err_n6", 32'(err_6), 32'(e_err6));
    checkOutput("setl_n6", 32'({lat_setl_6, busy_6}), 32'({e_setl, e_busy}));
  endtask

  // Random requesters that obey the hold-until-grant rule
  task automatic applyStimulus();
    resetl = ($urandom_range(0, 299) != 0);
    if (req0 ? e_gnt0 : ($urandom_range(0, 2) == 0)) begin
      req0  = req0 ? 1'($urandom_range(0, 1)) : 1'b1;
      addr0 = AW'($urandom_range(0, 7));
      data0 = DW'($urandom);
    end
    if (req1 ? e_gnt1 : ($urandom_range(0, 2) == 0)) begin
      req1  = req1 ? 1'($urandom_range(0, 1)) : 1'b1;
      addr1 = AW'($urandom_range(0, 7));
      data1 = DW'($urandom);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    modelEdge();
    @(negedge sys_clk);
    compareAll();
    if (auto_mode) applyStimulus();
  endtask

  // Counts cycles of low lat_setl after release, bounded
  task automatic countPreset(input string tag);
    int n = 0;
    int guard = 0;
    resetl = 1'b1;
    while (guard < 20) begin
      step();
      guard++;
      if (lat_setl == 1'b0) n++;
      else break;
    end
    checkOutput(tag, 32'(n), 32'(PC));
    checkOutput({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    resetl = 1'b0;
    req0 = 1'b1; addr0 = 3'd0; data0 = 16'h0BAD;
    req1 = 1'b0; addr1 = 3'd0; data1 = 16'h0000;
    step(); step();
    checkOutput("rst_setl", 32'(lat_setl), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(1));
    checkOutput("rst_en", 32'(lat_en), 32'(0));

    countPreset("preset_len");
    step();
    checkOutput("first_gnt", 32'(gnt0), 32'(1));
    req0 = 1'b0;
    step(); step();

    req0 = 1'b1; addr0 = 3'd5; data0 = 16'hA5C3;
    step();
    checkOutput("single_gnt", 32'(gnt0), 32'(1));
    req0 = 1'b0;
    step();
    checkOutput("single_en", 32'(lat_en), 32'h20);
    checkOutput("single_d", 32'(lat_d), 32'hA5C3);
    step();
    checkOutput("single_idle", 32'(lat_en), 32'(0));

    // single port-1 write leaves the pointer on port 0
    req1 = 1'b1; addr1 = 3'd0; data1 = 16'h0101;
    step();
    req1 = 1'b0;
    step(); step();

    req0 = 1'b1; addr0 = 3'd1; data0 = 16'h1001;
    req1 = 1'b1; addr1 = 3'd2; data1 = 16'h2002;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i < 6) checkOutput("cont_gnt0", 32'(gnt0), 32'((i % 2) == 0));
      if (i > 0) checkOutput("cont_en", 32'(lat_en), ((i - 1) % 2 == 0) ? 32'h02 : 32'h04);
      if (i == 5) begin req0 = 1'b0; req1 = 1'b0; end
    end
    step();

    req0 = 1'b1; addr0 = 3'd3; data0 = 16'h1111;
    req1 = 1'b1; addr1 = 3'd3; data1 = 16'h2222;
    step();
    checkOutput("coll_gnt0", 32'(gnt0), 32'(1));
    req0 = 1'b0;
    step();
    checkOutput("coll_gnt1", 32'(gnt1), 32'(1));
    checkOutput("coll_d1", 32'(lat_d), 32'h1111);
    checkOutput("coll_en1", 32'(lat_en), 32'h08);
    req1 = 1'b0;
    step();
    checkOutput("coll_d2", 32'(lat_d), 32'h2222);
    checkOutput("coll_en2", 32'(lat_en), 32'h08);
    step();

    req1 = 1'b1; addr1 = 3'd7; data1 = 16'h7777;
    step();
    checkOutput("oor_gnt1", 32'(gnt1_6), 32'(1));
    req1 = 1'b0;
    step();
    checkOutput("oor_err", 32'(err_6), 32'(1));
    checkOutput("oor_en", 32'(lat_en_6), 32'(0));
    step();
    checkOutput("oor_err_end", 32'(err_6), 32'(0));

    req0 = 1'b1; addr0 = 3'd2; data0 = 16'hBEEF;
    step();
    checkOutput("rmw_gnt", 32'(gnt0), 32'(1));
    req0 = 1'b0; resetl = 1'b0;
    step();
    checkOutput("rmw_en", 32'(lat_en), 32'(0));
    checkOutput("rmw_setl", 32'(lat_setl), 32'(0));
    countPreset("rmw_preset");

    auto_mode = 1;
    applyStimulus();
    for (int i = 0; i < 2000; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
